deserializer: RTL and testbench

Burst-aware serial-to-parallel converter. It sits directly downstream of the serializer and reconstructs the parallel word and its bit count from the MSB-first serial bursts that the serializer emits. For each burst it emits one registered parallel word plus a recovered length field. Bursts of illegal length are flagged and dropped.

---
 rtl/deserializer.sv | 100 ++++++++++
 tb/tb_deserializer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/deserializer.sv
// Burst-aware serial-to-parallel converter: rebuilds left-aligned words from MSB-first serial bursts.
// Emits one registered word + length per burst; bursts shorter than MIN_LEN raise an error strobe instead.
module deserializer #(
  parameter int WIDTH   = 16,
  parameter int MOD_W   = $clog2(WIDTH),
  parameter int MIN_LEN = 3
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             ser_data_i,
  input  logic             ser_data_val_i,
  output logic [WIDTH-1:0] deser_data_o,
  output logic [MOD_W-1:0] deser_data_mod_o,
  output logic             deser_data_val_o,
  output logic             deser_err_o,
  output logic             busy_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_LEN);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   sr;
  logic [WIDTH-1:0]   sr_ins;
  logic [MOD_W-1:0]   bit_idx;

  // Shift register with the current bit dropped into its slot, counted down from the MSB.
  always_comb begin
    // NOTE: assign every always_comb output a default first so no path leaves it unassigned (latch).
    sr_ins  = sr;
    bit_idx = MOD_W'(WIDTH - 1) - cnt[MOD_W-1:0];
    sr_ins[bit_idx] = ser_data_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state            <= IDLE;
      cnt              <= '0;
      sr               <= '0;
      deser_data_o     <= '0;
      deser_data_mod_o <= '0;
      deser_data_val_o <= 1'b0;
      deser_err_o      <= 1'b0;
      busy_o           <= 1'b0;
    end else begin
      deser_data_val_o <= 1'b0;
      deser_err_o      <= 1'b0;
      case (state)
        IDLE: begin
          if (ser_data_val_i) begin
            sr     <= {ser_data_i, {(WIDTH-1){1'b0}}};
            cnt    <= CNT_W'(1);
            state  <= COLLECT;
            busy_o <= 1'b1;
          end
        end
        COLLECT: begin
          if (ser_data_val_i) begin
            if (cnt == LAST_CNT) begin
              // Full word: emit with the final bit included; a new burst may start next cycle.
              deser_data_o     <= sr_ins;
              deser_data_mod_o <= '0;
              deser_data_val_o <= 1'b1;
              sr               <= '0;
              cnt              <= '0;
              state            <= IDLE;
              busy_o           <= 1'b0;
            end else begin
              sr  <= sr_ins;
              cnt <= cnt + 1'b1;
            end
          end else begin
            if (cnt >= MIN_CNT) begin
              deser_data_o     <= sr;
              deser_data_mod_o <= cnt[MOD_W-1:0];
              deser_data_val_o <= 1'b1;
            end else begin
              deser_err_o <= 1'b1;
            end
            sr     <= '0;
            cnt    <= '0;
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          cnt    <= '0;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_deserializer.sv
// Self-checking bench for deserializer: table-driven bursts, hand-written corner sequences,
// and randomized traffic compared every cycle against a queue-based reference model.
module tb_deserializer;

  logic        clk_i = 1'b0;
  logic        srst_i = 1'b1;
  logic        ser_data_i = 1'b0;
  logic        ser_data_val_i = 1'b0;
  logic [15:0] deser_data_o;
  logic [3:0]  deser_data_mod_o;
  logic        deser_data_val_o;
  logic        deser_err_o;
  logic        busy_o;

  deserializer #(.WIDTH(16), .MOD_W(4), .MIN_LEN(3)) dut (
    .clk_i            (clk_i),
    .srst_i           (srst_i),
    .ser_data_i       (ser_data_i),
    .ser_data_val_i   (ser_data_val_i),
    .deser_data_o     (deser_data_o),
    .deser_data_mod_o (deser_data_mod_o),
    .deser_data_val_o (deser_data_val_o),
    .deser_err_o      (deser_err_o),
    .busy_o           (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: bits of the current burst held in a queue, outputs derived from burst length.
  bit          q[$];
  logic [15:0] m_data = '0;
  logic [3:0]  m_mod  = '0;
  logic        m_val  = 1'b0;
  logic        m_err  = 1'b0;

  function automatic logic [15:0] pack_bits();
    logic [15:0] w = '0;
    for (int i = 0; i < q.size(); i++) w[15-i] = q[i];
    return w;
  endfunction

  task automatic model_edge(input logic rst, input logic val, input logic d);
    m_val = 1'b0;
    m_err = 1'b0;
    if (rst) begin
      q.delete();
      m_data = '0;
      m_mod  = '0;
    end else if (val) begin
      q.push_back(d);
      if (q.size() == 16) begin
        m_data = pack_bits();
        m_mod  = 4'd0;
        m_val  = 1'b1;
        q.delete();
      end
    end else if (q.size() > 0) begin
      if (q.size() >= 3) begin
        m_data = pack_bits();
        m_mod  = 4'(q.size());
        m_val  = 1'b1;
      end else begin
        m_err = 1'b1;
      end
      q.delete();
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, compare all outputs 1 time unit later.
  task automatic step(input logic rst, input logic val, input logic d);
    srst_i         = rst;
    ser_data_val_i = val;
    ser_data_i     = d;
    @(posedge clk_i);
    model_edge(rst, val, d);
    #1;
    check("model.val",  32'(deser_data_val_o), 32'(m_val));
    check("model.err",  32'(deser_err_o),      32'(m_err));
    check("model.busy", 32'(busy_o),           32'(q.size() > 0));
    check("model.data", 32'(deser_data_o),     32'(m_data));
    check("model.mod",  32'(deser_data_mod_o), 32'(m_mod));
  endtask

  typedef struct {
    logic [15:0] bits;
    int          len;
    logic [15:0] exp_data;
    logic [3:0]  exp_mod;
    logic        exp_err;
  } vec_t;

  vec_t tbl[8];

  logic [31:0] b2b_word;
  int          strobe_at[$];
  logic [15:0] strobe_data[$];
  logic [6:0]  pre;

  initial begin
    // Burst table: 16'hBEEF rows mirror a serializer sending data_mod 0, 3, 9, 15.
    tbl[0] = '{16'hA5C3, 16, 16'hA5C3, 4'd0,  1'b0};
    tbl[1] = '{16'hB000, 5,  16'hB000, 4'd5,  1'b0};
    tbl[2] = '{16'hC000, 2,  16'hB000, 4'd5,  1'b1};
    tbl[3] = '{16'hBEEF, 16, 16'hBEEF, 4'd0,  1'b0};
    tbl[4] = '{16'hBEEF, 3,  16'hA000, 4'd3,  1'b0};
    tbl[5] = '{16'hBEEF, 9,  16'hBE80, 4'd9,  1'b0};
    tbl[6] = '{16'hBEEF, 15, 16'hBEEE, 4'd15, 1'b0};
    tbl[7] = '{16'h8000, 1,  16'hBEEE, 4'd15, 1'b1};

    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    check("reset.data", 32'(deser_data_o), 32'h0);
    check("reset.mod",  32'(deser_data_mod_o), 32'h0);
    check("reset.strobes", {30'd0, deser_data_val_o, deser_err_o}, 32'h0);
    check("reset.busy", 32'(busy_o), 32'h0);
    step(1'b0, 1'b0, 1'b0);

    foreach (tbl[r]) begin
      for (int i = 0; i < tbl[r].len; i++) begin
        step(1'b0, 1'b1, tbl[r].bits[15-i]);
        if (i == 0) check("tbl.busy_rise_early", 32'(busy_o), 32'(1));
      end
      // Full words strobe 1 cycle after the last bit; shorter bursts need the gap cycle first.
      if (tbl[r].len < 16) step(1'b0, 1'b0, 1'b0);
      check($sformatf("tbl%0d.val", r),  32'(deser_data_val_o), 32'(!tbl[r].exp_err));
      check($sformatf("tbl%0d.err", r),  32'(deser_err_o),      32'(tbl[r].exp_err));
      check($sformatf("tbl%0d.data", r), 32'(deser_data_o),     32'(tbl[r].exp_data));
      check($sformatf("tbl%0d.mod", r),  32'(deser_data_mod_o), 32'(tbl[r].exp_mod));
      check($sformatf("tbl%0d.busy", r), 32'(busy_o),           32'(0));
      step(1'b0, 1'b0, 1'b0);
    end

    // Back-to-back full words with val held high for 32 cycles.
    b2b_word = 32'h1234_FFFF;
    for (int c = 0; c < 32; c++) begin
      step(1'b0, 1'b1, b2b_word[31-c]);
      if (deser_data_val_o) begin
        strobe_at.push_back(c);
        strobe_data.push_back(deser_data_o);
      end
    end
    step(1'b0, 1'b0, 1'b0);
    check("b2b.count", 32'(strobe_at.size()), 32'(2));
    if (strobe_at.size() == 2) begin
      check("b2b.first_at",  32'(strobe_at[0]), 32'(15));
      check("b2b.spacing",   32'(strobe_at[1] - strobe_at[0]), 32'(16));
      check("b2b.word0",     32'(strobe_data[0]), 32'h1234);
      check("b2b.word1",     32'(strobe_data[1]), 32'hFFFF);
    end

    // Reset mid-burst after 7 bits (val held high through reset), then a 3-bit burst.
    pre = 7'b1011011;
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, pre[6-i]);
    step(1'b1, 1'b1, 1'b1);
    check("rst_mid.busy", 32'(busy_o), 32'(0));
    check("rst_mid.data", 32'(deser_data_o), 32'h0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check("rst_mid.val",  32'(deser_data_val_o), 32'(1));
    check("rst_mid.word", 32'(deser_data_o), 32'hA000);
    check("rst_mid.mod",  32'(deser_data_mod_o), 32'(3));

    // Reset coinciding with the gap cycle suppresses the pending strobe.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    check("rst_gap.val",  32'(deser_data_val_o), 32'(0));
    check("rst_gap.data", 32'(deser_data_o), 32'h0);
    step(1'b0, 1'b0, 1'b0);
    check("rst_gap.still_quiet", 32'(deser_data_val_o), 32'(0));

    // New burst starting in the very cycle the previous burst's strobe is high.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check("overlap.strobe", 32'(deser_data_val_o), 32'(1));
    step(1'b0, 1'b1, 1'b1);
    check("overlap.busy", 32'(busy_o), 32'(1));
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check("overlap.word2", 32'(deser_data_o), 32'hA000);
    step(1'b0, 1'b0, 1'b0);

    // Randomized traffic with occasional resets, checked cycle by cycle.
    for (int c = 0; c < 3000; c++) begin
      step(1'($urandom_range(0, 299) == 0),
           1'($urandom_range(0, 9) < 8),
           1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
